// File: rtl/ti_share_decoder_pkg.sv
// ti_share_decoder_pkg: shared TI constants and decoder state enumeration
package ti_share_decoder_pkg;
  localparam int NIBBLE_W = 4;
  localparam int SHARES = 3;
  typedef enum logic {COLLECT, OUTPUT} state_t;
endpackage

// File: rtl/ti_share_xor3.sv
// ti_share_xor3: stage A share registers (glitch barrier) followed by 3-share XOR recombination; ports clk, rst, en (beat accepted), sh0..sh2 (shares), valid (stage A holds a beat), nib (recombined nibble)
module ti_share_xor3
  import ti_share_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NIBBLE_W-1:0] sh0,
  input  logic [NIBBLE_W-1:0] sh1,
  input  logic [NIBBLE_W-1:0] sh2,
  output logic                valid,
  output logic [NIBBLE_W-1:0] nib
);
  logic [NIBBLE_W-1:0] r0, r1, r2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      valid <= 1'b0;
    end else begin
      r0 <= en ? sh0 : '0;
      r1 <= en ? sh1 : '0;
      r2 <= en ? sh2 : '0;
      valid <= en;
    end
  end
  assign nib = r0 ^ r1 ^ r2;
endmodule

// File: rtl/ti_share_decoder.sv
// ti_share_decoder: collects NIBBLES masked share beats, unmasks each nibble and emits one packed word; ports clk, rst, s_valid/s_ready/s_sh0..2 (share beats in), m_valid/m_ready/m_data (word out), busy
module ti_share_decoder #(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [3:0]         s_sh0,
  input  logic [3:0]         s_sh1,
  input  logic [3:0]         s_sh2,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [4*NIBBLES-1:0] m_data,
  output logic               busy
);
  import ti_share_decoder_pkg::NIBBLE_W;
  import ti_share_decoder_pkg::state_t;
  import ti_share_decoder_pkg::COLLECT;
  import ti_share_decoder_pkg::OUTPUT;
  localparam int CW = $clog2(NIBBLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NIBBLE_W*NIBBLES-1:0] acc;
  logic a_v, b_v, b_last, take, give;
  logic [NIBBLE_W-1:0] nib;
  assign m_valid = state == OUTPUT;
  assign s_ready = state == COLLECT && cnt < CW'(NIBBLES);
  assign take = s_valid && s_ready;
  assign give = m_valid && m_ready;
  assign m_data = acc;
  assign busy = cnt != '0 || a_v || b_v || m_valid;
  if (SHARES == 3) begin : g_xor
    ti_share_xor3 u_xor3 (
      .clk(clk),
      .rst(rst),
      .en(take),
      .sh0(s_sh0),
      .sh1(s_sh1),
      .sh2(s_sh2),
      .valid(a_v),
      .nib(nib)
    );
  end else begin : g_none
    assign a_v = 1'b0;
    assign nib = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == COLLECT ? (b_last ? OUTPUT : COLLECT) : (m_ready ? COLLECT : OUTPUT);
  end
  // The stage-A beat was counted on its accept edge, so its slot is cnt-1 here;
  // a beat accepted on this same edge only bumps cnt afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      b_v <= 1'b0;
      b_last <= 1'b0;
    end else begin
      b_v <= a_v;
      b_last <= a_v && cnt == CW'(NIBBLES);
      if (give) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        if (take) cnt <= cnt + 1'b1;
        for (int i = 0; i < NIBBLES; i++)
          if (a_v && cnt == CW'(i + 1)) acc[NIBBLE_W*i +: NIBBLE_W] <= nib;
      end
    end
  end
endmodule

// File: tb/tb_ti_share_decoder.sv
// tb_ti_share_decoder: randomized and directed self-checking bench against a beat-count model
module tb_ti_share_decoder;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 1;
  logic [3:0] s_sh0 = 0, s_sh1 = 0, s_sh2 = 0;
  logic s_ready, m_valid, busy;
  logic [63:0] m_data;
  int tests = 0, fails = 0;
  int n = 0, dly = 0;
  logic exp_mv = 0;
  logic [63:0] word = 0;

  ti_share_decoder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_sh0(s_sh0), .s_sh1(s_sh1), .s_sh2(s_sh2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a word is the XOR of each of the first 16 accepted beats in order;
  // it appears 2 edges after the 16th accept and stays until taken.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0; word <= 0; exp_mv <= 0; dly <= 0;
    end else begin
      if (exp_mv && m_ready) begin
        n <= 0; word <= 0; exp_mv <= 0;
      end else if (s_valid && n < 16) begin
        word[4*n +: 4] <= s_sh0 ^ s_sh1 ^ s_sh2;
        n <= n + 1;
        if (n == 15) dly <= 2;
      end
      if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) exp_mv <= 1;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("s_ready", {63'd0, s_ready}, {63'd0, n < 16});
    chk("m_valid", {63'd0, m_valid}, {63'd0, exp_mv});
    chk("busy", {63'd0, busy}, {63'd0, n != 0});
    if (exp_mv || n == 0) chk("m_data", m_data, word);
  end

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    s_valid = 1; s_sh0 = a; s_sh1 = b; s_sh2 = c;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 0; s_sh0 = 0; s_sh1 = 0; s_sh2 = 0;
    @(posedge clk); #1;
  endtask

  logic [3:0] ra, rb;
  logic [3:0] stage_or;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst = 0;
    #1 chk("rst_s_ready", {63'd0, s_ready}, 64'd1);

    // back-to-back, xor = k
    m_ready = 1;
    for (int k = 0; k < 16; k++) beat(4'(k), 4'hA, 4'hA);
    idle(); chk("t1_lat1", {63'd0, m_valid}, 64'd0);
    idle(); chk("t1_lat2", {63'd0, m_valid}, 64'd1);
    chk("t1_data", m_data, 64'hFEDCBA9876543210);
    chk("t1_model", word, 64'hFEDCBA9876543210);
    idle(); chk("t1_once", {63'd0, m_valid}, 64'd0);
    chk("t1_cleared", m_data, 64'd0);

    // back-pressure with random shares recombining to 5
    m_ready = 0;
    for (int k = 0; k < 16; k++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      beat(ra, rb, ra ^ rb ^ 4'h5);
    end
    idle(); idle();
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold", m_data, 64'h5555555555555555);
      chk("t2_valid", {63'd0, m_valid}, 64'd1);
      chk("t2_sready", {63'd0, s_ready}, 64'd0);
      idle();
    end
    @(negedge clk); m_ready = 1;
    @(posedge clk); #1;
    chk("t2_taken", {63'd0, m_valid}, 64'd0);

    // beats offered during OUTPUT are ignored
    m_ready = 0;
    for (int k = 0; k < 16; k++) beat(4'($urandom), 4'h0, 4'h0);
    idle(); idle(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_valid = 1; s_sh0 = 4'hF; s_sh1 = 0; s_sh2 = 0;
      @(posedge clk); #1;
      chk("t3_blocked", {63'd0, s_ready}, 64'd0);
    end
    @(negedge clk); m_ready = 1;
    @(posedge clk); #1;
    chk("t3_ready", {63'd0, s_ready}, 64'd1);
    for (int k = 0; k < 16; k++) beat(4'(k), 4'h0, 4'h0);
    idle(); idle();
    chk("t3_data", m_data, 64'hFEDCBA9876543210);
    idle();

    // reset mid-collection
    for (int k = 0; k < 7; k++) beat(4'($urandom), 4'($urandom), 4'($urandom));
    @(negedge clk); s_valid = 0; rst = 1;
    #1;
    chk("t4_m_valid", {63'd0, m_valid}, 64'd0);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_m_data", m_data, 64'd0);
    @(negedge clk); rst = 0;
    for (int k = 0; k < 16; k++) beat(4'(k), 4'h3, 4'h3);
    idle(); idle();
    chk("t4_data", m_data, 64'hFEDCBA9876543210);
    idle();

    // gaps of 3 idle cycles; stage A must hold no stale shares
    for (int k = 0; k < 16; k++) begin
      beat(4'(k ^ 6), 4'h6, 4'h0);
      for (int j = 0; j < 3; j++) begin
        idle();
        stage_or = dut.g_xor.u_xor3.r0 | dut.g_xor.u_xor3.r1 | dut.g_xor.u_xor3.r2;
        chk("t5_stage_a", {60'd0, stage_or}, 64'd0);
        if (k == 15 && j == 1) chk("t5_data", m_data, 64'hFEDCBA9876543210);
      end
    end

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom); s_sh0 = 4'($urandom); s_sh1 = 4'($urandom); s_sh2 = 4'($urandom);
      m_ready = ($urandom % 3) != 0;
    end
    @(negedge clk); s_valid = 0; m_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
